// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of the single-port unified memory
// between instruction fetch and load/store. Memory address, data and byte
// write enables come straight from flops so they are stable across the
// memory's negedge write. Stores are converted to byte lanes here, and
// misaligned or illegal stores are acked with d_err and never write.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  f_req,
   input  logic [ADDR_WIDTH-1:0] f_addr,
   output logic                  f_ack,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [1:0]            d_size,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_ack,
   output logic                  d_err,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic [3:0]            mem_we,
   input  logic [DATA_WIDTH-1:0] mem_q
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   // last_grant encoding: which port was granted most recently
   localparam logic PORT_F = 1'b0;
   localparam logic PORT_D = 1'b1;

   state_t                  state_q, state_d;
   logic                    last_grant_q, last_grant_d;
   logic                    err_pend_q, err_pend_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
   logic [3:0]              mem_we_q, mem_we_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    f_ack_q, f_ack_d;
   logic                    d_ack_q, d_ack_d;
   logic                    d_err_q, d_err_d;

   logic                    grant_f, grant_d;
   logic [3:0]              st_we;
   logic [DATA_WIDTH-1:0]   st_data;
   logic                    st_err;

   // The fetch address is forced word-aligned, so its low bits are dropped.
   logic unused_f_addr_bits;
   assign unused_f_addr_bits = ^f_addr[1:0];

   // Decode the data port into byte-lane enables and lane-replicated data
   always_comb begin
      st_we   = 4'b0000;
      st_data = '0;
      st_err  = 1'b0;
      if (d_we) begin
         case (d_size)
            2'b00: begin
               st_we   = 4'b0001 << d_addr[1:0];
               st_data = {4{d_wdata[7:0]}};
            end
            2'b01: begin
               if (!d_addr[0]) begin
                  st_we   = d_addr[1] ? 4'b1100 : 4'b0011;
                  st_data = {2{d_wdata[15:0]}};
               end else begin
                  st_err = 1'b1;
               end
            end
            2'b10: begin
               if (d_addr[1:0] == 2'b00) begin
                  st_we   = 4'b1111;
                  st_data = d_wdata;
               end else begin
                  st_err = 1'b1;
               end
            end
            default: st_err = 1'b1;
         endcase
      end
   end

   // Next-state, grant selection and next values of every output flop
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      err_pend_d   = err_pend_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      mem_we_d     = mem_we_q;
      rdata_d      = rdata_q;
      f_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      d_err_d      = 1'b0;
      grant_f      = 1'b0;
      grant_d      = 1'b0;
      case (state_q)
         IDLE: begin
            // On contention the port that did not go last wins
            if (f_req && (!d_req || last_grant_q == PORT_D)) begin
               grant_f = 1'b1;
            end else if (d_req) begin
               grant_d = 1'b1;
            end
         end
         ACCESS: begin
            rdata_d  = mem_q;
            mem_we_d = 4'b0000;
            if (last_grant_q == PORT_F) begin
               f_ack_d = 1'b1;
            end else begin
               d_ack_d = 1'b1;
               d_err_d = err_pend_q;
            end
            state_d = DONE;
         end
         DONE: begin
            // The port just served may still hold req high; only the other
            // port can be granted directly from here.
            if (last_grant_q == PORT_D && f_req) begin
               grant_f = 1'b1;
            end else if (last_grant_q == PORT_F && d_req) begin
               grant_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (grant_f) begin
         mem_addr_d   = {f_addr[ADDR_WIDTH-1:2], 2'b00};
         mem_data_d   = '0;
         mem_we_d     = 4'b0000;
         err_pend_d   = 1'b0;
         last_grant_d = PORT_F;
         state_d      = ACCESS;
      end else if (grant_d) begin
         mem_addr_d   = {d_addr[ADDR_WIDTH-1:2], 2'b00};
         mem_data_d   = st_data;
         mem_we_d     = st_we;
         err_pend_d   = st_err;
         last_grant_d = PORT_D;
         state_d      = ACCESS;
      end
   end

   // State and output registers; reset clears everything at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= PORT_D;
         err_pend_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         mem_we_q     <= 4'b0000;
         rdata_q      <= '0;
         f_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         d_err_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         err_pend_q   <= err_pend_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         mem_we_q     <= mem_we_d;
         rdata_q      <= rdata_d;
         f_ack_q      <= f_ack_d;
         d_ack_q      <= d_ack_d;
         d_err_q      <= d_err_d;
      end
   end

   assign f_ack    = f_ack_q;
   assign d_ack    = d_ack_q;
   assign d_err    = d_err_q;
   assign rdata    = rdata_q;
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign mem_we   = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-lane RAM that writes
// on negedge and reads combinationally, like the real unified memory.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_ack;
   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic        d_err;
   logic [31:0] rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic [3:0]  mem_we;
   logic [31:0] mem_q;

   int n_checks = 0;
   int n_fails  = 0;

   logic [31:0] ram [0:255] = '{1: 32'hCAFE_0001, 2: 32'h1357_9BDF, default: 32'h0};

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .f_req    (f_req),
      .f_addr   (f_addr),
      .f_ack    (f_ack),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_size   (d_size),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_ack    (d_ack),
      .d_err    (d_err),
      .rdata    (rdata),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_we   (mem_we),
      .mem_q    (mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model: combinational read, byte-lane write on negedge
   assign mem_q = ram[mem_addr[9:2]];
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mem_we[i]) ram[mem_addr[9:2]][8*i +: 8] <= mem_data[8*i +: 8];
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected end of test");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // one data-port transaction through IDLE -> ACCESS -> DONE -> IDLE
   task automatic data_access(input string tag, input logic we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] exp_we, input logic [31:0] exp_data,
                              input logic exp_err, input logic [31:0] exp_rdata,
                              input logic chk_rdata);
      d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
      tick;
      check({tag, "_acc_we"}, {28'h0, mem_we}, {28'h0, exp_we});
      check({tag, "_acc_addr"}, mem_addr, {addr[31:2], 2'b00});
      check({tag, "_acc_ack"}, {31'h0, d_ack}, 32'h0);
      if (we && !exp_err) check({tag, "_acc_data"}, mem_data, exp_data);
      tick;
      check({tag, "_done_ack"}, {31'h0, d_ack}, 32'h1);
      check({tag, "_done_err"}, {31'h0, d_err}, {31'h0, exp_err});
      check({tag, "_done_we"}, {28'h0, mem_we}, 32'h0);
      check({tag, "_done_fack"}, {31'h0, f_ack}, 32'h0);
      if (chk_rdata) check({tag, "_rdata"}, rdata, exp_rdata);
      d_req = 1'b0;
      tick;
      check({tag, "_idle_ack"}, {31'h0, d_ack}, 32'h0);
      check({tag, "_idle_err"}, {31'h0, d_err}, 32'h0);
      $display("txn %s: we=%0b size=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0b",
               tag, we, size, addr, wdata, rdata, exp_err);
   endtask

   initial begin
      rst = 1'b1; f_req = 1'b0; f_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
      tick; tick;
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_data", mem_data, 32'h0);
      check("rst_mem_we", {28'h0, mem_we}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_acks", {29'h0, f_ack, d_ack, d_err}, 32'h0);
      rst = 1'b0;
      tick;

      // fetch from 0x6 -> word address 0x4, returns ram[1]
      f_req = 1'b1; f_addr = 32'h0000_0006;
      tick;
      check("fetch_acc_addr", mem_addr, 32'h4);
      check("fetch_acc_we", {28'h0, mem_we}, 32'h0);
      check("fetch_acc_ack", {31'h0, f_ack}, 32'h0);
      tick;
      check("fetch_done_ack", {31'h0, f_ack}, 32'h1);
      check("fetch_rdata", rdata, 32'hCAFE_0001);
      check("fetch_done_dack", {31'h0, d_ack}, 32'h0);
      check("fetch_done_we", {28'h0, mem_we}, 32'h0);
      f_req = 1'b0;
      tick;
      check("fetch_idle_ack", {31'h0, f_ack}, 32'h0);
      $display("txn fetch: addr=0x00000006 rdata=0x%08h", rdata);

      // word store then load back
      data_access("st_word",   1'b1, 2'b10, 32'h200, 32'h1234_5678, 4'b1111, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
      data_access("ld_word",   1'b0, 2'b10, 32'h200, 32'h0,         4'b0000, 32'h0,         1'b0, 32'h1234_5678, 1'b1);
      // zero the word, then byte and half lane stores
      data_access("st_zero",   1'b1, 2'b10, 32'h200, 32'h0,         4'b1111, 32'h0,         1'b0, 32'h0, 1'b0);
      data_access("st_byte",   1'b1, 2'b00, 32'h201, 32'h0000_00AA, 4'b0010, 32'hAAAA_AAAA, 1'b0, 32'h0, 1'b0);
      data_access("st_half",   1'b1, 2'b01, 32'h202, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0, 1'b0);
      data_access("ld_lanes",  1'b0, 2'b10, 32'h200, 32'h0,         4'b0000, 32'h0,         1'b0, 32'hBEEF_AA00, 1'b1);
      // misaligned / illegal stores: error ack, no write
      data_access("st_half_mis", 1'b1, 2'b01, 32'h201, 32'h0000_1111, 4'b0000, 32'h0, 1'b1, 32'h0, 1'b0);
      data_access("st_word_mis", 1'b1, 2'b10, 32'h202, 32'h2222_2222, 4'b0000, 32'h0, 1'b1, 32'h0, 1'b0);
      data_access("st_size11",   1'b1, 2'b11, 32'h200, 32'h3333_3333, 4'b0000, 32'h0, 1'b1, 32'h0, 1'b0);
      data_access("ld_after_err", 1'b0, 2'b10, 32'h200, 32'h0, 4'b0000, 32'h0, 1'b0, 32'hBEEF_AA00, 1'b1);

      // both ports requesting continuously from reset: fetch, data, fetch
      rst = 1'b1;
      f_req = 1'b1; f_addr = 32'h8;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h200;
      tick;
      rst = 1'b0;
      tick;
      check("rr1_addr", mem_addr, 32'h8);
      tick;
      check("rr1_fack", {31'h0, f_ack}, 32'h1);
      check("rr1_dack", {31'h0, d_ack}, 32'h0);
      check("rr1_rdata", rdata, 32'h1357_9BDF);
      tick;
      check("rr2_addr", mem_addr, 32'h200);
      check("rr2_acks", {30'h0, f_ack, d_ack}, 32'h0);
      tick;
      check("rr2_dack", {31'h0, d_ack}, 32'h1);
      check("rr2_fack", {31'h0, f_ack}, 32'h0);
      check("rr2_rdata", rdata, 32'hBEEF_AA00);
      tick;
      check("rr3_addr", mem_addr, 32'h8);
      check("rr3_acks", {30'h0, f_ack, d_ack}, 32'h0);
      tick;
      check("rr3_fack", {31'h0, f_ack}, 32'h1);
      $display("txn round_robin: fetch/data/fetch acks observed two cycles apart");

      // reset in the middle of a store's ACCESS cycle, before the negedge
      rst = 1'b1;
      f_req = 1'b0; d_req = 1'b0;
      tick;
      rst = 1'b0;
      tick;
      d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h204; d_wdata = 32'h55;
      tick;
      check("rstmid_acc_we", {28'h0, mem_we}, 32'h1);
      check("rstmid_acc_data", mem_data, 32'h5555_5555);
      #1;
      rst = 1'b1;
      #1;
      check("rstmid_we", {28'h0, mem_we}, 32'h0);
      check("rstmid_addr", mem_addr, 32'h0);
      d_req = 1'b0;
      tick;
      check("rstmid_acks", {29'h0, f_ack, d_ack, d_err}, 32'h0);
      rst = 1'b0;
      tick;
      check("rstmid_idle_acks", {29'h0, f_ack, d_ack, d_err}, 32'h0);
      $display("txn reset_mid_access: store to 0x204 aborted");
      data_access("ld_after_rst", 1'b0, 2'b10, 32'h204, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
